// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;
  localparam int NSLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_demux4_decoder2to4.sv
// One-hot write-enable decoder; mirrors the transmit-side 4:1 mux select.
module decoder2to4
  import tdm_pkg::*;
(
  input  slot_t             sel_i,
  input  logic              en_i,
  output logic [NSLOTS-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) we_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: aligns on slot-0 sync, collects four beats and
// presents them as parallel lanes with a one-cycle valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             valid,
  output logic             locked,
  output logic             sync_err,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  slot_t            slot_q, slot_d;
  slot_t            cap_sel;
  logic             cap_en;
  logic             bad_sync;
  logic [NSLOTS-1:0] we;
  logic [WIDTH-1:0] shadow_q [NSLOTS-1];
  logic [WIDTH-1:0] y_q      [NSLOTS];
  logic             valid_q, sync_err_q, locked_q;

  // A sync beat always restarts at slot 0; otherwise only a mid-frame
  // LOCKED beat is kept. The slot-3 enable doubles as the output load strobe.
  always_comb begin
    cap_sel  = sync ? slot_t'(0) : slot_q;
    cap_en   = en && (sync || (state_q == LOCKED && slot_q != 2'd0));
    bad_sync = en && (state_q == LOCKED) &&
               (sync ? (slot_q != 2'd0) : (slot_q == 2'd0));

    state_d = state_q;
    if (en) begin
      if (sync)                                       state_d = LOCKED;
      else if (state_q == LOCKED && slot_q == 2'd0)   state_d = HUNT;
    end

    slot_d = cap_en ? slot_t'(cap_sel + 2'd1) : slot_q;
  end

  decoder2to4 u_dec (
    .sel_i (cap_sel),
    .en_i  (cap_en),
    .we_o  (we)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      locked_q   <= 1'b0;
      for (int i = 0; i < NSLOTS - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NSLOTS; i++)     y_q[i]      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      locked_q   <= (state_d == LOCKED);
      valid_q    <= we[NSLOTS-1];
      sync_err_q <= bad_sync;
      for (int i = 0; i < NSLOTS - 1; i++)
        if (we[i]) shadow_q[i] <= din;
      if (we[NSLOTS-1]) begin
        for (int i = 0; i < NSLOTS - 1; i++) y_q[i] <= shadow_q[i];
        y_q[NSLOTS-1] <= din;
      end
    end
  end

  assign y0        = y_q[0];
  assign y1        = y_q[1];
  assign y2        = y_q[2];
  assign y3        = y_q[3];
  assign valid     = valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = locked_q;
  assign state_dbg = state_q;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receiving end of a 4-slot time-division channel: the transmit side drives a 4:1 mux from a 2-bit slot counter, and this block takes that serialized stream back apart. It accepts one `WIDTH`-bit beat per enabled cycle, aligns to a frame-sync marker on slot 0, and collects four beats into four parallel lane registers. It then presents all lanes together with a one-cycle `valid` pulse. It also tracks lock and flags sync errors.

## Interface
- `WIDTH`, default 4: bits per slot/lane.
- `clk`  in  1: rising-edge clock; the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `din`  in  WIDTH: serialized slot data.
- `en`  in  1: beat strobe; `din`/`sync` are sampled only when `en`=1.
- `sync`  in  1: marks the current beat as slot 0 of a frame.
- `y0`,`y1`,`y2`,`y3`  out  WIDTH each: demultiplexed lanes; hold value between frames.
- `valid`  out  1: one-cycle pulse when `y0..y3` update with a complete frame.
- `locked`  out  1: high in state LOCKED.
- `sync_err`  out  1: one-cycle pulse on a framing violation.

## Operation
- States: HUNT (reset state) and LOCKED.
- Slot counter `slot` is 2 bits, used only in LOCKED. It advances by one on each accepted beat and wraps 3→0.
- HUNT:
  - `en & sync`: beat is captured as slot 0 into shadow register 0, `slot`←1, go to LOCKED.
  - `en & !sync`: beat is discarded and the block stays in HUNT. No `sync_err` is raised in HUNT.
- LOCKED, `en`=1:
  - `slot`=0 with `sync`=1: capture into shadow 0, `slot`←1.
  - `slot`=0 with `sync`=0: missing sync. Pulse `sync_err`, discard the beat, go to HUNT.
  - `slot`∈{1,2} with `sync`=0: capture into shadow[`slot`], `slot`++.
  - `slot`=3 with `sync`=0: `y0..y2`←shadow 0..2, `y3`←`din`, pulse `valid`, `slot`←0.
  - `slot`≠0 with `sync`=1: early sync. Pulse `sync_err`, drop the partial frame (`y` unchanged, no `valid`), capture this beat as the new slot 0, `slot`←1, stay in LOCKED.
- Any state, `en`=0: no state change. `sync` is ignored. Gaps between beats are legal at any slot.
- Shadow registers are not visible on the outputs. `y0..y3` change only when `valid` pulses.
- Reset (async assert, any time, including mid-frame):
  - State HUNT, `slot`=0.
  - Shadows, `y0..y3`, `valid`, `locked` and `sync_err` all clear to 0.
  - Any partial frame is lost.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `valid` and the new `y0..y3` appear in the cycle after the edge that samples the slot-3 beat: one cycle of latency from the last beat.
- `sync_err` is high for exactly the one cycle after the offending beat's edge.
- `locked` rises the cycle after the first accepted sync and falls the cycle after a missing-sync beat.
- Back-to-back frames with `en` held high give `valid` every 4th cycle.
- `valid` and `sync_err` are never high in the same cycle.
- Reset deassertion is synchronized externally. The first beat can be accepted on the first edge after `reset_n` rises.

## Structure
- Package `tdm_pkg`:
  - `NSLOTS` = 4.
  - `slot_t` = `logic [1:0]`.
  - `state_t` enum {HUNT, LOCKED}.
- Sub-module `decoder2to4`: combinational. Maps `slot` plus a capture enable to one-hot shadow-register write enables; it mirrors the transmit-side mux select.
- Top level holds the FSM, slot counter, shadow registers and output registers.

## Test plan
- Reset then aligned frame: `en`=1 continuous; beats 4'h1 (`sync`=1), 4'h2, 4'h3, 4'h4 → one cycle after the 4th beat, `valid`=1 and `y0..y3`=1,2,3,4. `locked`=1 from the cycle after beat 1.
- Gapped frame: the same four beats with `en`=0 for 2 cycles between every beat → same `y` values. `valid` pulses exactly once, one cycle after beat 4.
- Pre-sync garbage: beats 4'hF, 4'hE with `sync`=0, then the aligned frame 5,6,7,8 → `locked` stays 0 until the sync beat, no `sync_err`, `y`=5,6,7,8.
- Early sync: after frame 1,2,3,4, send 9 (`sync`), A, then B with `sync`=1, then C, D, E → `sync_err` pulses after B, no `valid` for the partial 9/A frame, then `y`=B,C,D,E with `valid`.
- Missing sync: after a good frame, a beat 4'h0 with `sync`=0 at slot 0 → `sync_err` pulses, `locked`→0. A following 1,2,3,4 without sync produces no `valid`.
- Reset mid-frame: assert `reset_n`=0 after 2 beats of a frame → all outputs 0 immediately (asynchronous). After release, a full frame 1,2,3,4 is required before any `valid`.
